// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared grid constants, FSM encoding and cursor wrap helper
package sudoku_pkg;

    localparam int GRID_N  = 9;
    localparam int CELL_W  = 7;
    localparam int DIGIT_W = 4;
    localparam int POS_W   = 4;

    localparam logic [DIGIT_W-1:0] CLEAR_DIGIT = '0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_REJECT = 3'd4
    } state_t;

    // Step a cursor coordinate by +1 (inc=1) or -1 (inc=0), wrapping inside 0..n-1
    function automatic logic [POS_W-1:0] wrap_step(input logic [POS_W-1:0] pos,
                                                   input logic             inc,
                                                   input int               n);
        logic [POS_W-1:0] res;
        if (inc) begin
            res = (int'(pos) >= n - 1) ? '0 : pos + 1'b1;
        end else begin
            res = (pos == '0) ? POS_W'(n - 1) : pos - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sudoku_entry_ctrl_btn_edge.sv
// rtl/sudoku_entry_ctrl_btn_edge.sv - registered button level with rising-edge pulse
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    // Remember last cycle's level so a press is seen exactly once
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/sudoku_entry_ctrl.sv
// rtl/sudoku_entry_ctrl.sv - cursor navigation and read-check-write move sequencer
module sudoku_entry_ctrl
    import sudoku_pkg::*;
#(
    parameter int N             = GRID_N,
    parameter int STABLE_CYCLES = 4,
    parameter int ACK_TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] switch_cod,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_confirm,
    input  logic               cell_fixed,
    input  logic               wr_ack,
    output logic               rd_en,
    output logic               wr_en,
    output logic [DIGIT_W-1:0] wr_data,
    output logic [CELL_W-1:0]  addr,
    output logic [POS_W-1:0]   cursor_row,
    output logic [POS_W-1:0]   cursor_col,
    output logic               busy,
    output logic               reject
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);

    state_t             state;
    state_t             state_nx;
    logic [DIGIT_W-1:0] switch_q;
    logic [STAB_W-1:0]  stab_cnt;
    logic [TMO_W-1:0]   ack_cnt;
    logic               up_rise;
    logic               down_rise;
    logic               left_rise;
    logic               right_rise;
    logic               confirm_rise;
    logic               stable;
    logic               go;
    logic               ack_expired;

    btn_edge u_edge_up      (.clk(clk), .reset(reset), .level(btn_up),      .rise(up_rise));
    btn_edge u_edge_down    (.clk(clk), .reset(reset), .level(btn_down),    .rise(down_rise));
    btn_edge u_edge_left    (.clk(clk), .reset(reset), .level(btn_left),    .rise(left_rise));
    btn_edge u_edge_right   (.clk(clk), .reset(reset), .level(btn_right),   .rise(right_rise));
    btn_edge u_edge_confirm (.clk(clk), .reset(reset), .level(btn_confirm), .rise(confirm_rise));

    assign stable      = (stab_cnt == STAB_W'(STABLE_CYCLES));
    assign go          = (state == ST_IDLE) && confirm_rise && stable;
    assign ack_expired = (ack_cnt == TMO_W'(ACK_TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: confirm starts a read, fixed cells and missing acks end in REJECT
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (go) state_nx = ST_READ;
            ST_READ:   state_nx = ST_CHECK;
            ST_CHECK:  state_nx = cell_fixed ? ST_REJECT : ST_WRITE;
            ST_WRITE: begin
                if (wr_ack) begin
                    state_nx = ST_IDLE;
                end else if (ack_expired) begin
                    state_nx = ST_REJECT;
                end
            end
            ST_REJECT: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Strobes decoded purely from the current state
    always_comb begin
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        reject = 1'b0;
        busy   = (state != ST_IDLE);
        case (state)
            ST_READ:   rd_en  = 1'b1;
            ST_WRITE:  wr_en  = 1'b1;
            ST_REJECT: reject = 1'b1;
            default:   ;
        endcase
    end

    // Switch stability: count unchanged cycles, saturating at the confirm threshold
    always_ff @(posedge clk) begin
        if (reset) begin
            switch_q <= '0;
            stab_cnt <= '0;
        end else begin
            switch_q <= switch_cod;
            if (switch_cod != switch_q) begin
                stab_cnt <= '0;
            end else if (!stable) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    // Cursor moves only in IDLE, one move per cycle, frozen once a confirm is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            cursor_row <= '0;
            cursor_col <= '0;
        end else if (state == ST_IDLE && !go) begin
            if (up_rise) begin
                cursor_row <= wrap_step(cursor_row, 1'b0, N);
            end else if (down_rise) begin
                cursor_row <= wrap_step(cursor_row, 1'b1, N);
            end else if (left_rise) begin
                cursor_col <= wrap_step(cursor_col, 1'b0, N);
            end else if (right_rise) begin
                cursor_col <= wrap_step(cursor_col, 1'b1, N);
            end
        end
    end

    // Linear cell index follows the cursor one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
        end else begin
            addr <= CELL_W'(int'(cursor_row) * N + int'(cursor_col));
        end
    end

    // Capture the digit at the moment the move is confirmed
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_data <= CLEAR_DIGIT;
        end else if (go) begin
            wr_data <= switch_cod;
        end
    end

    // Count cycles spent waiting for the board to acknowledge a write
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_cnt <= '0;
        end else if (state == ST_CHECK) begin
            ack_cnt <= '0;
        end else if (state == ST_WRITE) begin
            ack_cnt <= ack_cnt + 1'b1;
        end
    end

endmodule

// File: doc/sudoku_entry_ctrl.md
Name: sudoku_entry_ctrl

Overview:
Sequences a player's move into the Sudoku board memory. It takes the priority-encoded switch value (0–9) and the synchronized push-buttons, and maintains a cursor over the 9x9 grid. On confirm, it runs a read-check-write transaction against the board, refusing writes to fixed (puzzle-given) cells. It sits between the switch encoder / button synchronizers and the board RAM controller.

Parameters:
N, 9, grid dimension; cursor range 0..N-1.
STABLE_CYCLES, 4, consecutive unchanged cycles of switch_cod required before a confirm is accepted.
ACK_TIMEOUT, 15, maximum cycles spent in WRITE waiting for wr_ack before aborting.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
switch_cod  in  4  encoded switch value, 0 = clear cell, 1..9 = digit
btn_up / btn_down / btn_left / btn_right  in  1 each  synchronized button levels
btn_confirm  in  1  synchronized confirm button level
cell_fixed  in  1  board fixed flag; valid in the cycle after rd_en
wr_ack  in  1  board write acknowledge
rd_en  out  1  one-cycle read strobe for the fixed flag at addr
wr_en  out  1  write request; held until ack or timeout
wr_data  out  4  digit to write (latched switch_cod)
addr  out  7  cell index = row*N + col, range 0..80
cursor_row / cursor_col  out  4 each  current cursor position
busy  out  1  high whenever state != IDLE
reject  out  1  one-cycle pulse: write refused (fixed cell or timeout)

Behaviour:
- Reset values: all outputs 0, cursor (0,0), state IDLE, stability counter 0, button-history registers 0.
- Edge detection: each button has a registered previous level. An event is level=1 while previous=0.
- Navigation is accepted in IDLE only:
  - Up/down adjust row; left/right adjust col.
  - Wrap-around: 0 -1 -> N-1, N-1 +1 -> 0.
  - Simultaneous events: priority up > down > left > right; one move per cycle; the losing events are dropped.
  - Navigation events outside IDLE are discarded.
- Stability counter:
  - Resets to 0 on any cycle where switch_cod differs from its registered copy.
  - Otherwise increments, saturating at STABLE_CYCLES.
- addr is always row*N + col, registered, recomputed one cycle after a cursor change.
- FSM states: IDLE, READ, CHECK, WRITE, REJECT.
  - IDLE -> READ: on a confirm edge with counter == STABLE_CYCLES. Latch wr_data <= switch_cod and freeze the cursor. A confirm edge with the counter unsaturated is ignored.
  - READ: rd_en=1 for exactly this cycle -> CHECK.
  - CHECK: sample cell_fixed. If 1 -> REJECT; else -> WRITE with the timeout counter cleared.
  - WRITE: wr_en=1; wr_data and addr held stable.
    - wr_ack=1 -> IDLE; wr_en is 0 from the next cycle.
    - After ACK_TIMEOUT cycles without ack -> REJECT.
  - REJECT: reject=1 for this single cycle -> IDLE.
- Latency:
  - Confirm edge sampled at edge k -> rd_en high in cycle k+1.
  - cell_fixed sampled at edge k+2 -> wr_en high from cycle k+2 (CHECK -> WRITE at edge k+2).
  - Zero-wait ack gives busy for 3 cycles.
- wr_ack outside WRITE is ignored. Confirm edges while busy are dropped, not queued.
- Value 0 is a legal write (clears the cell).
- Reset mid-transaction: returns to IDLE at that edge; wr_en/rd_en/reject are 0 in the following cycle; the cursor returns to (0,0).

Decomposition:
- Shared package (sudoku_pkg): N, cell-index width (7), digit width (4), FSM state encoding, CLEAR_DIGIT=0.
- One natural sub-module: btn_edge (registered level + rising-edge pulse), instantiated for the five buttons.
- The FSM and cursor stay in this block.

Test Plan:
1. Reset, then btn_right x9 and btn_up x1 edges -> col wraps 0..8->0; row wraps 0->8 (up from 0); addr=72.
2. switch_cod=5 stable 4 cycles, confirm, cell_fixed=0, wr_ack on first WRITE cycle -> rd_en at k+1, wr_en=1 with wr_data=5 and addr=current cell for exactly one cycle, busy for 3 cycles.
3. switch_cod changes 3->7, confirm 2 cycles later -> no rd_en, state stays IDLE; re-confirm after 4 stable cycles -> wr_data=7.
4. Confirm on a cell with cell_fixed=1 -> single-cycle reject pulse, wr_en never asserted, back to IDLE.
5. WRITE with wr_ack held 0 -> wr_en high 15 cycles, then reject pulse, then IDLE; a late wr_ack is ignored.
6. Assert reset during WRITE; press up+left in the same IDLE cycle -> outputs cleared next cycle; only the row moves.
